lab_soc_pio_out: RTL and testbench
==================================

# lab_soc_pio_out

Parametrised Avalon-MM output PIO for the Lab SoC. It replaces the fixed 1-bit output-port peripherals (HPI chip-select, reset, read/write strobes) with one block that has:
- configurable output width;
- atomic bit set and bit clear registers;
- an optional hardware one-shot pulse generator, so software can emit timed strobes without toggling bits twice.

It sits on the Nios II data master bus, and `out_port` drives board-level control pins.

## Interface
Parameters:
- `WIDTH`, 8, number of output bits, legal range 1..32.
- `RESET_VALUE`, 0, value loaded into the data register on reset; WIDTH bits.
- `CNT_WIDTH`, 16, width of the pulse-length register and the pulse counter.

Ports:
- `clk` input 1: single clock. All state is on the rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `address` input 3: register select (word index).
- `chipselect` input 1: Avalon slave select.
- `write_n` input 1: active-low write strobe, qualified by `chipselect`.
- `writedata` input 32: write data; only bits [WIDTH-1:0] are used, except at address 5.
- `readdata` output 32: read data, combinational from `address`, zero-extended.
- `out_port` output WIDTH: data register OR active pulse mask.
- `pulse_busy` output 1: high while any pulse bit is active.

## Operation
Register map (a write = `chipselect && !write_n`):
- 0 DATA, R/W: write loads `data`; read returns `data`.
- 1 PINS, RO: read returns `out_port`; writes ignored.
- 2 OUTSET, WO: `data <= data | wd`; reads 0.
- 3 OUTCLR, WO: `data <= data & ~wd`; reads 0.
- 4 PULSE, R/W: write applies a pulse mask (rules below); read returns the active `pmask`.
- 5 PLEN, R/W: `plen <= writedata[CNT_WIDTH-1:0]`; read returns `plen`.
- 6, 7: read 0; writes ignored.

Output and reset:
- `out_port = data | pmask`.
- `pulse_busy = |pmask`.
- Reset values: `data = RESET_VALUE`, `pmask = 0`, `cnt = 0`, `plen = 1`, `out_port = RESET_VALUE`, `pulse_busy = 0`.

PULSE write with `wd != 0`:
- `pmask <= pmask | wd`.
- `cnt <= max(plen, 1)`. A `plen` of 0 is treated as 1.
- While busy this is a retrigger: new bits are OR-ed in and the counter reloads for all active bits.

PULSE write with `wd == 0`: no effect.

Counter:
- When not being loaded and `cnt > 1`: `cnt <= cnt - 1`.
- When `cnt == 1` and no PULSE write in the same cycle: `pmask <= 0`, `cnt <= 0`.
- A PULSE write in the expiry cycle wins. Counter reload and mask OR happen; the old bits are not cleared.

Interactions:
- DATA, OUTSET and OUTCLR writes do not touch `pmask` or `cnt`. A pulse bit stays high even if its DATA bit is cleared.
- Writes to PLEN during a pulse affect only the next load.
- `reset` asserted mid-pulse immediately returns all state to the reset values.

## Timing
- Write latency: a register write at edge N is visible on `out_port` and `readdata` after edge N. No wait states.
- Read latency: 0. `readdata` is valid in the same cycle as `address`.
- Pulse length: a PULSE write at edge N with `plen = L` gives `out_port` pulse bits high after edges N through N+L-1, exactly L cycles. The bits drop after edge N+L. `pulse_busy` has the same timing.
- Retrigger: a retrigger at edge M extends every active bit until edge M+L.

## Configuration
`LAB_SOC_PIO_PULSE_EN`:
- Defined: the PULSE and PLEN registers, the counter and the `pmask` logic are compiled in.
- Undefined:
  - addresses 4 and 5 read 0 and ignore writes;
  - `pmask` is constant 0, so `out_port = data`;
  - `pulse_busy` is tied 0;
  - no counter flops are generated.
- The `pulse_busy` port exists in both builds.

## Test plan
- Reset: WIDTH=8, RESET_VALUE=0x5A, assert `reset` → `out_port = 0x5A`, read addr 5 = 1, `pulse_busy = 0`.
- Atomic ops: DATA=0x0F, OUTSET 0x30, OUTCLR 0x03 → `out_port = 0x3C`; reads of addr 0 and addr 1 both return 0x3C.
- Pulse: PLEN=3, DATA=0, PULSE 0x81 at edge N → `out_port = 0x81` for exactly 3 cycles, 0x00 after edge N+3; `pulse_busy` tracks it.
- Retrigger: PLEN=4, PULSE 0x01 at N, PULSE 0x02 at N+2 → 0x01, 0x01, 0x03 ×4, then 0x00 after edge N+6.
- Boundaries:
  - PLEN=0, PULSE 0x01 → 1-cycle pulse.
  - PULSE write landing in the expiry cycle → no gap in the output.
  - `reset` asserted at `cnt = 2` → `out_port = RESET_VALUE` immediately.
- Macro off: PULSE 0xFF → `out_port` unchanged; read addr 4 = 0; `pulse_busy = 0`.

Source files
------------

// File: rtl/lab_soc_pio_out.sv
// lab_soc_pio_out
//   Parametrised Avalon-MM output PIO with atomic set/clear registers and an
//   optional hardware one-shot pulse generator.
//
//   Optional feature macro: LAB_SOC_PIO_PULSE_EN
//     defined   -> PULSE (addr 4) / PLEN (addr 5) registers, pulse counter and
//                  pulse mask are built.
//     undefined -> addr 4/5 read 0 and ignore writes, out_port = data,
//                  pulse_busy = 0, no counter flops.
//
//   Ports
//     clk         single clock, rising edge
//     reset       asynchronous, active-high
//     address     word index of the register to access
//     chipselect  Avalon slave select
//     write_n     active-low write strobe, qualified by chipselect
//     writedata   write data ([WIDTH-1:0] used, [CNT_WIDTH-1:0] at PLEN)
//     readdata    combinational read data, zero-extended
//     out_port    data register OR active pulse mask
//     pulse_busy  high while any pulse bit is active
//
//   Register map: 0 DATA rw, 1 PINS ro, 2 OUTSET wo, 3 OUTCLR wo,
//                 4 PULSE rw, 5 PLEN rw, 6/7 read 0.
//   WIDTH legal range 1..32; CNT_WIDTH is expected to be 1..32.
module lab_soc_pio_out #(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter int               CNT_WIDTH   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port,
  output logic             pulse_busy
);

  localparam logic [2:0] A_DATA   = 3'd0;
  localparam logic [2:0] A_PINS   = 3'd1;
  localparam logic [2:0] A_OUTSET = 3'd2;
  localparam logic [2:0] A_OUTCLR = 3'd3;
`ifdef LAB_SOC_PIO_PULSE_EN
  localparam logic [2:0] A_PULSE  = 3'd4;
  localparam logic [2:0] A_PLEN   = 3'd5;
`endif

  logic             wr;
  logic [WIDTH-1:0] wd;
  logic [WIDTH-1:0] data_q, data_d;
  logic [WIDTH-1:0] pmask;

  assign wr = chipselect & ~write_n;
  assign wd = writedata[WIDTH-1:0];

  // ---------------------------------------------------------------------------
  // Data register with atomic set / clear
  // ---------------------------------------------------------------------------
  always_comb begin
    data_d = data_q;
    if (wr) begin
      case (address)
        A_DATA:   data_d = wd;
        A_OUTSET: data_d = data_q | wd;
        A_OUTCLR: data_d = data_q & ~wd;
        default:  data_d = data_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) data_q <= RESET_VALUE;
    else       data_q <= data_d;
  end

`ifdef LAB_SOC_PIO_PULSE_EN
  // ---------------------------------------------------------------------------
  // One-shot pulse generator.
  // cnt holds the number of cycles the active mask still has to stay high,
  // counting the current one; cnt == 0 <=> pmask == 0.
  // ---------------------------------------------------------------------------
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  logic [WIDTH-1:0]     pmask_q, pmask_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0] plen_q, plen_d;
  logic                 pulse_ld;
  logic                 plen_ld;

  assign pulse_ld = wr && (address == A_PULSE) && (wd != '0);
  assign plen_ld  = wr && (address == A_PLEN);

  always_comb begin
    pmask_d = pmask_q;
    cnt_d   = cnt_q;
    plen_d  = plen_ld ? writedata[CNT_WIDTH-1:0] : plen_q;
    // A load takes priority over expiry, so a write landing in the last
    // cycle keeps the old bits and the output never gaps.
    if (pulse_ld) begin
      pmask_d = pmask_q | wd;
      cnt_d   = (plen_q == '0) ? CNT_ONE : plen_q;
    end else if (cnt_q > CNT_ONE) begin
      cnt_d = cnt_q - CNT_ONE;
    end else if (cnt_q == CNT_ONE) begin
      pmask_d = '0;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pmask_q <= '0;
      cnt_q   <= '0;
      plen_q  <= CNT_ONE;
    end else begin
      pmask_q <= pmask_d;
      cnt_q   <= cnt_d;
      plen_q  <= plen_d;
    end
  end

  assign pmask      = pmask_q;
  assign pulse_busy = |pmask_q;
`else
  logic unused_wd;

  assign unused_wd  = ^writedata;
  assign pmask      = '0;
  assign pulse_busy = 1'b0;
`endif

  assign out_port = data_q | pmask;

  // ---------------------------------------------------------------------------
  // Zero-wait-state read mux
  // ---------------------------------------------------------------------------
  always_comb begin
    readdata = '0;
    case (address)
      A_DATA: readdata[WIDTH-1:0] = data_q;
      A_PINS: readdata[WIDTH-1:0] = out_port;
`ifdef LAB_SOC_PIO_PULSE_EN
      A_PULSE: readdata[WIDTH-1:0]     = pmask_q;
      A_PLEN:  readdata[CNT_WIDTH-1:0] = plen_q;
`endif
      default: readdata = '0;
    endcase
  end

endmodule

// File: tb/tb_lab_soc_pio_out.sv
// Self-checking bench for lab_soc_pio_out (WIDTH=8, RESET_VALUE=0x5A).
// Works in both builds: the reference model reads LAB_SOC_PIO_PULSE_EN.
module tb_lab_soc_pio_out;

  localparam int         W  = 8;
  localparam logic [7:0] RV = 8'h5A;
`ifdef LAB_SOC_PIO_PULSE_EN
  localparam bit PEN = 1'b1;
`else
  localparam bit PEN = 1'b0;
`endif

  logic        clk        = 1'b0;
  logic        reset      = 1'b0;
  logic [2:0]  address    = 3'd0;
  logic        chipselect = 1'b0;
  logic        write_n    = 1'b1;
  logic [31:0] writedata  = 32'd0;
  logic [31:0] readdata;
  logic [W-1:0] out_port;
  logic        pulse_busy;

  always #5 clk = ~clk;

  lab_soc_pio_out #(.WIDTH(W), .RESET_VALUE(RV), .CNT_WIDTH(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .out_port   (out_port),
    .pulse_busy (pulse_busy)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: pulse bits are kept as a mask plus the absolute edge
  // number at which they expire; they are visible while ec < m_end.
  // ---------------------------------------------------------------------------
  longint     ec     = 0;
  longint     m_end  = 0;
  logic [7:0] m_data = RV;
  logic [7:0] m_pm   = 8'h00;
  logic [15:0] m_plen = 16'd1;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_data = RV; m_pm = 8'h00; m_end = 0; m_plen = 16'd1; ec = 0;
    end else begin
      ec = ec + 1;
      if (chipselect && !write_n) begin
        case (address)
          3'd0: m_data = writedata[7:0];
          3'd2: m_data = m_data | writedata[7:0];
          3'd3: m_data = m_data & ~writedata[7:0];
          3'd4: if (PEN && writedata[7:0] != 8'h00) begin
                  m_pm  = (((ec - 1) < m_end) ? m_pm : 8'h00) | writedata[7:0];
                  m_end = ec + ((m_plen == 16'd0) ? 1 : longint'(m_plen));
                end
          3'd5: if (PEN) m_plen = writedata[15:0];
          default: ;
        endcase
      end
    end
  end

  function automatic logic [7:0] m_pvis();
    return (ec < m_end) ? m_pm : 8'h00;
  endfunction

  function automatic logic [7:0] m_out();
    return m_data | m_pvis();
  endfunction

  function automatic logic [31:0] m_rd(input logic [2:0] a);
    case (a)
      3'd0: return {24'd0, m_data};
      3'd1: return {24'd0, m_out()};
      3'd4: return PEN ? {24'd0, m_pvis()} : 32'd0;
      3'd5: return PEN ? {16'd0, m_plen} : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  // Per-cycle compare, sampled away from the active edge after inputs settle.
  bit chk_en = 1'b0;
  always @(negedge clk) begin
    #1;
    if (chk_en) begin
      chk("out_port", 32'(out_port), 32'(m_out()));
      chk("pulse_busy", 32'(pulse_busy), 32'(m_pvis() != 8'h00));
      chk("readdata", readdata, m_rd(address));
    end
  end

  task automatic cyc(input bit c, input bit w, input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    chipselect = c; write_n = ~w; address = a; writedata = d;
  endtask

  logic [7:0] rt_exp [7];
  logic [7:0] ex_exp [5];

  initial begin
    rt_exp = '{8'h01, 8'h01, 8'h03, 8'h03, 8'h03, 8'h03, 8'h00};
    ex_exp = '{8'h01, 8'h01, 8'h05, 8'h05, 8'h00};

    #1 reset = 1'b1;
    repeat (2) @(negedge clk);
    chk_en  = 1'b1;
    address = 3'd5;
    #1;
    chk("rst_out", 32'(out_port), 32'(RV));
    chk("rst_plen", readdata, PEN ? 32'd1 : 32'd0);
    chk("rst_busy", 32'(pulse_busy), 32'd0);
    @(negedge clk) reset = 1'b0;

    // Atomic set / clear
    cyc(1, 1, 3'd0, 32'h0F);
    cyc(1, 1, 3'd2, 32'h30);
    cyc(1, 1, 3'd3, 32'h03);
    cyc(0, 0, 3'd0, 32'h0);
    #1;
    chk("atomic_out", 32'(out_port), 32'h3C);
    chk("atomic_rd0", readdata, 32'h3C);
    cyc(0, 0, 3'd1, 32'h0);
    #1 chk("atomic_rd1", readdata, 32'h3C);

    // Basic pulse, 3 cycles
    cyc(1, 1, 3'd0, 32'h0);
    cyc(1, 1, 3'd5, 32'd3);
    cyc(1, 1, 3'd4, 32'h81);
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, 3'd4, 32'h0);
      #1;
      chk("pulse_out", 32'(out_port), (PEN && i < 3) ? 32'h81 : 32'h00);
      chk("pulse_busy_lit", 32'(pulse_busy), (PEN && i < 3) ? 32'd1 : 32'd0);
    end

    // Retrigger
    cyc(1, 1, 3'd5, 32'd4);
    cyc(1, 1, 3'd4, 32'h01);
    for (int i = 0; i < 7; i++) begin
      if (i == 1) cyc(1, 1, 3'd4, 32'h02);
      else        cyc(0, 0, 3'd4, 32'h0);
      #1 chk("retrig_out", 32'(out_port), PEN ? 32'(rt_exp[i]) : 32'h00);
    end

    // PLEN = 0 behaves as 1
    cyc(1, 1, 3'd5, 32'd0);
    cyc(1, 1, 3'd4, 32'h01);
    cyc(0, 0, 3'd0, 32'h0);
    #1 chk("plen0_hi", 32'(out_port), PEN ? 32'h01 : 32'h00);
    cyc(0, 0, 3'd0, 32'h0);
    #1 chk("plen0_lo", 32'(out_port), 32'h00);

    // Write landing in the expiry cycle
    cyc(1, 1, 3'd5, 32'd2);
    cyc(1, 1, 3'd4, 32'h01);
    for (int i = 0; i < 5; i++) begin
      if (i == 1) cyc(1, 1, 3'd4, 32'h04);
      else        cyc(0, 0, 3'd1, 32'h0);
      #1 chk("expiry_out", 32'(out_port), PEN ? 32'(ex_exp[i]) : 32'h00);
    end

    // Reset mid-pulse at cnt == 2
    cyc(1, 1, 3'd5, 32'd3);
    cyc(1, 1, 3'd0, 32'h00);
    cyc(1, 1, 3'd4, 32'h80);
    cyc(0, 0, 3'd0, 32'h0);
    #1 chk("midrst_pre", 32'(out_port), PEN ? 32'h80 : 32'h00);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("midrst_out", 32'(out_port), 32'(RV));
    chk("midrst_busy", 32'(pulse_busy), 32'd0);
    @(negedge clk) reset = 1'b0;

    // PULSE 0xFF: visible only in the pulse build
    cyc(1, 1, 3'd0, 32'h11);
    cyc(1, 1, 3'd4, 32'hFF);
    cyc(0, 0, 3'd4, 32'h0);
    #1;
    chk("pen_out", 32'(out_port), PEN ? 32'hFF : 32'h11);
    chk("pen_rd4", readdata, PEN ? 32'hFF : 32'h00);
    chk("pen_busy", 32'(pulse_busy), PEN ? 32'd1 : 32'd0);

    // Randomized traffic against the model
    repeat (1500) begin
      @(negedge clk);
      reset      = ($urandom_range(0, 149) == 0);
      chipselect = ($urandom_range(0, 3) != 0);
      write_n    = ($urandom_range(0, 2) == 0);
      address    = 3'($urandom_range(0, 7));
      if (address == 3'd5)      writedata = 32'($urandom_range(0, 6)) | ($urandom & 32'hFFFF_0000);
      else if ($urandom_range(0, 4) == 0) writedata = $urandom & 32'hFFFF_FF00;
      else                      writedata = $urandom;
    end
    @(negedge clk);
    reset = 1'b0; chipselect = 1'b0; write_n = 1'b1;
    repeat (10) @(negedge clk);
    #2;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
